band_scan_gen: RTL

BAND_SCAN_GEN -- requirements
Module: band_scan_gen

---
 rtl/band_scan_gen_if.sv | 30 +++
 rtl/band_scan_gen.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/band_scan_gen_if.sv
// Handshake bundle between the band-scan address generator (master) and its
// consumer (slave).
interface band_scan_gen_if #(
    parameter int RW  = 8,
    parameter int CW  = 4,
    parameter int CHW = 2
);
    logic           start;
    logic           mode;
    logic           abort;
    logic           out_ready;
    logic           out_valid;
    logic [RW-1:0]  out_row;
    logic [CW-1:0]  out_col;
    logic [CHW-1:0] out_ch;
    logic           out_band_first;
    logic           out_last;
    logic           busy;
    logic           done;

    modport master (
        input  start, mode, abort, out_ready,
        output out_valid, out_row, out_col, out_ch, out_band_first, out_last, busy, done
    );

    modport slave (
        output start, mode, abort, out_ready,
        input  out_valid, out_row, out_col, out_ch, out_band_first, out_last, busy, done
    );
endinterface

// File: rtl/band_scan_gen.sv
// Band-scan address generator: channel -> band -> column -> row-in-band order,
// raster or serpentine column direction, ready/valid output with registered beats.
module band_scan_gen #(
    parameter int ROW  = 256,
    parameter int COL  = 16,
    parameter int BAND = 2,
    parameter int CH   = 3
) (
    input logic            clk,
    input logic            rst,
    band_scan_gen_if.master bus
);
    localparam int RW  = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int CW  = (COL > 1) ? $clog2(COL) : 1;
    localparam int CHW = (CH  > 1) ? $clog2(CH)  : 1;

    localparam logic [RW-1:0]  ROW_M1 = RW'(ROW - 1);
    localparam logic [CW-1:0]  COL_M1 = CW'(COL - 1);
    localparam logic [CHW-1:0] CH_M1  = CHW'(CH - 1);
    localparam logic [RW:0]    ROW_X  = (RW+1)'(ROW);
    localparam logic [RW:0]    BAND_X = (RW+1)'(BAND);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t         r_state;
    logic           r_mode;
    logic           r_odd;
    logic [RW-1:0]  r_base;
    logic [RW-1:0]  r_row;
    logic [CW-1:0]  r_col;
    logic [CHW-1:0] r_ch;
    logic           r_valid;
    logic           r_bfirst;
    logic           r_last;
    logic           r_busy;
    logic           r_done;

    logic           w_desc;
    logic [RW:0]    w_base_end;
    logic           w_row_end;
    logic           w_col_end;
    logic           w_last_band;
    logic [RW-1:0]  w_n_row;
    logic [RW-1:0]  w_n_base;
    logic [CW-1:0]  w_n_col;
    logic [CHW-1:0] w_n_ch;
    logic           w_n_odd;
    logic [RW:0]    w_n_base_end;
    logic           w_n_last;
    logic           w_n_bfirst;

    assign w_desc      = r_mode & r_odd;
    assign w_base_end  = {1'b0, r_base} + BAND_X;
    assign w_row_end   = (r_row == ROW_M1) || (({1'b0, r_row} + (RW+1)'(1)) == w_base_end);
    assign w_col_end   = w_desc ? (r_col == '0) : (r_col == COL_M1);
    assign w_last_band = (w_base_end >= ROW_X);

    // Successor of the current beat; band end uses the unclipped base+BAND so a
    // partial final band stops at ROW-1.
    always_comb begin
        w_n_row  = r_row;
        w_n_col  = r_col;
        w_n_ch   = r_ch;
        w_n_base = r_base;
        w_n_odd  = r_odd;
        if (!w_row_end) begin
            w_n_row = r_row + 1'b1;
        end else if (!w_col_end) begin
            w_n_row = r_base;
            w_n_col = w_desc ? (r_col - 1'b1) : (r_col + 1'b1);
        end else if (!w_last_band) begin
            w_n_base = w_base_end[RW-1:0];
            w_n_row  = w_base_end[RW-1:0];
            w_n_odd  = ~r_odd;
            w_n_col  = (r_mode & ~r_odd) ? COL_M1 : '0;
        end else begin
            w_n_ch   = r_ch + 1'b1;
            w_n_base = '0;
            w_n_row  = '0;
            w_n_odd  = 1'b0;
            w_n_col  = '0;
        end
    end

    assign w_n_base_end = {1'b0, w_n_base} + BAND_X;
    assign w_n_bfirst   = (w_n_row == w_n_base);
    assign w_n_last     = (w_n_ch == CH_M1) && (w_n_base_end >= ROW_X) && (w_n_row == ROW_M1) &&
                          (w_n_col == ((r_mode & w_n_odd) ? '0 : COL_M1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mode   <= 1'b0;
            r_odd    <= 1'b0;
            r_base   <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_ch     <= '0;
            r_valid  <= 1'b0;
            r_bfirst <= 1'b0;
            r_last   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state  <= SCAN;
                        r_mode   <= bus.mode;
                        r_odd    <= 1'b0;
                        r_base   <= '0;
                        r_row    <= '0;
                        r_col    <= '0;
                        r_ch     <= '0;
                        r_valid  <= 1'b1;
                        r_bfirst <= 1'b1;
                        r_last   <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                SCAN: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (r_valid && bus.out_ready) begin
                        if (r_last) begin
                            r_state <= DONE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_row    <= w_n_row;
                            r_col    <= w_n_col;
                            r_ch     <= w_n_ch;
                            r_base   <= w_n_base;
                            r_odd    <= w_n_odd;
                            r_bfirst <= w_n_bfirst;
                            r_last   <= w_n_last;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid      = r_valid;
    assign bus.out_row        = r_row;
    assign bus.out_col        = r_col;
    assign bus.out_ch         = r_ch;
    assign bus.out_band_first = r_bfirst;
    assign bus.out_last       = r_last;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
endmodule
